inst_prefetch_queue: RTL

INST_PREFETCH_QUEUE -- requirements
Module: inst_prefetch_queue

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/ipq_fifo.sv | 74 +++++++
 rtl/inst_prefetch_queue.sv | 115 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch front-end types: prefetch FSM states, queue entry, depth.
// Imported by the prefetch queue and its storage.
package cpu_pkg;

  localparam int IPQ_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } ipq_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ipq_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ipq_fifo.sv
// Prefetch queue storage: entry array, wrapping pointers, occupancy count.
// Flush dominates push and pop.
module ipq_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = IPQ_DEPTH
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [31:0]            wr_pc,
  input  logic [31:0]            wr_inst,
  output logic [31:0]            rd_pc,
  output logic [31:0]            rd_inst,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  ipq_entry_t    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (cnt_q != '0);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PTR_ONE;
      if (do_pop)  rptr_d = rptr_q + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload needs no reset; the top gates it with the valid flag.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= {wr_pc, wr_inst};
  end

  assign rd_pc   = mem_q[rptr_q].pc;
  assign rd_inst = mem_q[rptr_q].inst;
  assign count   = cnt_q;

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: one-outstanding fetch FSM feeding a small
// FIFO towards decode, with redirect flush and stale-ack discard.
module inst_prefetch_queue
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = IPQ_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   clrn,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_data,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   id_valid,
  output logic [31:0]            id_inst,
  output logic [31:0]            id_pc,
  output logic [31:0]            id_pc4,
  input  logic                   id_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  ipq_state_e    state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   pend_q, pend_d;
  logic          push;
  logic          pop;
  logic [CW-1:0] cnt;
  logic [31:0]   head_pc;
  logic [31:0]   head_inst;

  always_comb begin
    state_d = state_q;
    fpc_d   = fpc_q;
    pend_d  = pend_q;
    push    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (redirect) begin
          fpc_d = word_align(redirect_pc);
        end else if (cnt < DEPTH_C) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (redirect) begin
          if (imem_ack) begin
            fpc_d   = word_align(redirect_pc);
            state_d = ST_IDLE;
          end else begin
            pend_d  = word_align(redirect_pc);
            state_d = ST_DISCARD;
          end
        end else if (imem_ack) begin
          push    = 1'b1;
          fpc_d   = fpc_q + 32'd4;
          state_d = ST_IDLE;
        end
      end
      // Stale address stays on the bus until its ack is swallowed.
      ST_DISCARD: begin
        if (imem_ack) begin
          fpc_d   = redirect ? word_align(redirect_pc) : pend_q;
          state_d = ST_IDLE;
        end else if (redirect) begin
          pend_d = word_align(redirect_pc);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
      fpc_q   <= RESET_PC;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      pend_q  <= pend_d;
    end
  end

  assign pop = id_valid & id_ready;

  ipq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .clrn   (clrn),
    .flush  (redirect),
    .push   (push),
    .pop    (pop),
    .wr_pc  (fpc_q),
    .wr_inst(imem_data),
    .rd_pc  (head_pc),
    .rd_inst(head_inst),
    .count  (cnt)
  );

  assign imem_req  = (state_q != ST_IDLE);
  assign imem_addr = {fpc_q[31:2], 2'b00};
  assign count     = cnt;
  assign id_valid  = (cnt != '0);
  assign id_inst   = id_valid ? head_inst : '0;
  assign id_pc     = id_valid ? head_pc : '0;
  assign id_pc4    = id_valid ? head_pc + 32'd4 : '0;

endmodule
